// File: rtl/pim_pkg.sv
// pim_pkg: shared constants and types for the PIM macro controller.
//   - register offsets, relative to the controller base address
//   - CTRL write-bit and status read-bit positions
//   - controller FSM state encoding
//   - default unlock key for VREF/MODE writes
package pim_pkg;

    localparam logic [31:0] OFF_CTRL         = 32'h010;
    localparam logic [31:0] OFF_R            = 32'h020;
    localparam logic [31:0] OFF_W_WEIGHT     = 32'h040;
    localparam logic [31:0] OFF_W_ACTIVATION = 32'h080;
    localparam logic [31:0] OFF_W_KEY        = 32'h100;
    localparam logic [31:0] OFF_W_VREF       = 32'h200;
    localparam logic [31:0] OFF_W_MODE       = 32'h400;

    // CTRL write bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR      = 1;
    localparam int CTRL_WPTR_RST = 2;

    // CTRL read (status) bits; FIFO count sits in [15:8]
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_TO   = 3;
    localparam int ST_OVF  = 4;

    localparam logic [31:0] PIM_UNLOCK_KEY = 32'h0000_C0DE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/pim_res_fifo.sv
// pim_res_fifo: synchronous result FIFO with combinational head.
//   i_clk, i_rst_n : clock, async active-low reset (empties the FIFO)
//   push, wdata    : enqueue request and data
//   pop            : dequeue request (ignored when empty)
//   rdata          : current head, valid while !empty
//   full, empty    : status
//   count          : number of stored entries
// A push while full only lands if a pop happens in the same cycle.
module pim_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pim_ctrl.sv
// pim_ctrl: memory-mapped controller for the analog PIM macro.
//   Bus side  : i_pim_addr/i_pim_wr_data with one-cycle i_pim_write/i_pim_read
//               strobes; o_pim_rd_data is registered (valid cycle after read).
//   Macro side: weight row writes (o_macro_we/row/wdata), held activation,
//               vref and mode, o_macro_start pulse, i_macro_done/result.
//   o_busy    : compute in progress (ARM/WAIT/CAPTURE).
// Results are captured into a small FIFO drained through the R register.
module pim_ctrl
    import pim_pkg::*;
#(
    parameter int             XLEN       = 32,
    parameter logic [XLEN-1:0] BASE      = 32'h4000_0000,
    parameter int             ROWS       = 16,
    parameter int             RES_DEPTH  = 4,
    parameter int             TIMEOUT    = 1024,
    parameter logic [XLEN-1:0] UNLOCK_KEY = PIM_UNLOCK_KEY,
    localparam int            RAW        = $clog2(ROWS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_pim_addr,
    input  logic [XLEN-1:0] i_pim_wr_data,
    input  logic            i_pim_write,
    input  logic            i_pim_read,
    output logic [XLEN-1:0] o_pim_rd_data,
    output logic            o_macro_we,
    output logic [RAW-1:0]  o_macro_row,
    output logic [XLEN-1:0] o_macro_wdata,
    output logic [XLEN-1:0] o_macro_act,
    output logic [XLEN-1:0] o_macro_vref,
    output logic [3:0]      o_macro_mode,
    output logic            o_macro_start,
    input  logic            i_macro_done,
    input  logic [XLEN-1:0] i_macro_result,
    output logic            o_busy
);

    localparam int CW = $clog2(RES_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    // Address decode on the offset from BASE
    logic [XLEN-1:0] off;
    logic wr_ctrl, wr_wgt, wr_act, wr_key, wr_vref, wr_mode, rd_ctrl, rd_res;

    assign off     = i_pim_addr - BASE;
    assign wr_ctrl = i_pim_write && (off == XLEN'(OFF_CTRL));
    assign wr_wgt  = i_pim_write && (off == XLEN'(OFF_W_WEIGHT));
    assign wr_act  = i_pim_write && (off == XLEN'(OFF_W_ACTIVATION));
    assign wr_key  = i_pim_write && (off == XLEN'(OFF_W_KEY));
    assign wr_vref = i_pim_write && (off == XLEN'(OFF_W_VREF));
    assign wr_mode = i_pim_write && (off == XLEN'(OFF_W_MODE));
    assign rd_ctrl = i_pim_read  && (off == XLEN'(OFF_CTRL));
    assign rd_res  = i_pim_read  && (off == XLEN'(OFF_R));

    state_t          state, state_nx;
    logic [TW-1:0]   tcnt;
    logic [XLEN-1:0] res_q, key, f_head, status;
    logic [RAW-1:0]  wptr;
    logic            err, to, ovf, done;
    logic            push, pop, f_full, f_empty, timed_out, clr, unlocked;
    logic [CW-1:0]   f_count;

    assign timed_out = (state == WAIT) && !i_macro_done && (tcnt == TW'(TIMEOUT - 1));
    assign pop       = rd_res & ~f_empty;
    assign clr       = wr_ctrl & i_pim_wr_data[CTRL_CLR];
    assign unlocked  = (key == UNLOCK_KEY);

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (wr_ctrl && i_pim_wr_data[CTRL_START]) state_nx = ARM;
            ARM:     state_nx = WAIT;
            WAIT:    if (i_macro_done) state_nx = CAPTURE;
                     else if (timed_out) state_nx = IDLE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_macro_start = (state == ARM);
        o_busy        = (state != IDLE);
        push          = (state == CAPTURE);
    end

    // Timeout counter and result latch
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tcnt  <= '0;
            res_q <= '0;
        end else begin
            if (state == ARM)       tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + TW'(1);
            if (state == WAIT && i_macro_done) res_q <= i_macro_result;
        end
    end

    // Macro-facing registers; weight/activation writes are dropped while busy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_macro_we    <= 1'b0;
            o_macro_row   <= '0;
            o_macro_wdata <= '0;
            o_macro_act   <= '0;
            o_macro_vref  <= '0;
            o_macro_mode  <= '0;
            wptr          <= '0;
            key           <= '0;
        end else begin
            o_macro_we <= 1'b0;
            if (wr_wgt && !o_busy) begin
                o_macro_we    <= 1'b1;
                o_macro_row   <= wptr;
                o_macro_wdata <= i_pim_wr_data;
                wptr          <= wptr + RAW'(1);
            end else if (wr_ctrl && i_pim_wr_data[CTRL_WPTR_RST]) begin
                wptr <= '0;
            end
            if (wr_act && !o_busy)   o_macro_act  <= i_pim_wr_data;
            if (wr_key)              key          <= i_pim_wr_data;
            if (wr_vref && unlocked) o_macro_vref <= i_pim_wr_data;
            if (wr_mode && unlocked) o_macro_mode <= i_pim_wr_data[3:0];
        end
    end

    // Sticky flags; a set in the same cycle as a clear wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err  <= 1'b0;
            to   <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            err  <= (err & ~clr) | ((wr_wgt | wr_act) & o_busy);
            to   <= (to  & ~clr) | timed_out;
            ovf  <= (ovf & ~clr) | (push & f_full & ~pop);
            done <= (done & ~rd_ctrl) | push;
        end
    end

    always_comb begin
        status          = '0;
        status[ST_BUSY] = o_busy;
        status[ST_DONE] = done;
        status[ST_ERR]  = err;
        status[ST_TO]   = to;
        status[ST_OVF]  = ovf;
        status[15:8]    = 8'(f_count);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pim_rd_data <= '0;
        end else begin
            o_pim_rd_data <= '0;
            if (rd_ctrl)              o_pim_rd_data <= status;
            else if (rd_res && !f_empty) o_pim_rd_data <= f_head;
        end
    end

    pim_res_fifo #(.DEPTH(RES_DEPTH), .WIDTH(XLEN)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .wdata   (res_q),
        .pop     (pop),
        .rdata   (f_head),
        .full    (f_full),
        .empty   (f_empty),
        .count   (f_count)
    );

endmodule

// File: tb/tb_pim_ctrl.sv
// tb_pim_ctrl: scoreboard bench for pim_ctrl. Expected weight-row writes and
// result-register reads are queued when stimulus is driven and compared when
// the DUT produces them.
module tb_pim_ctrl;
    import pim_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] addr = '0, wdat = '0, rdata, mwdata, act, vref, mresult = '0;
    logic        wr = 1'b0, rd = 1'b0, mwe, mstart, mdone = 1'b0, busy;
    logic [3:0]  mrow, mode;

    int n_tests = 0, n_fail = 0;
    logic [31:0] rq[$];   // expected R-register reads
    logic [35:0] wq[$];   // expected weight writes {row, data}

    always #5 clk = ~clk;

    pim_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pim_addr(addr), .i_pim_wr_data(wdat), .i_pim_write(wr), .i_pim_read(rd),
        .o_pim_rd_data(rdata),
        .o_macro_we(mwe), .o_macro_row(mrow), .o_macro_wdata(mwdata),
        .o_macro_act(act), .o_macro_vref(vref), .o_macro_mode(mode),
        .o_macro_start(mstart), .i_macro_done(mdone), .i_macro_result(mresult),
        .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Weight-write monitor
    always @(negedge clk) begin
        logic [35:0] e;
        if (rst_n && mwe) begin
            if (wq.size() == 0) chk("we_unexpected", 32'(mwe), 32'h0);
            else begin
                e = wq.pop_front();
                chk("we_row", 32'(mrow), 32'(e[35:32]));
                chk("we_data", mwdata, e[31:0]);
            end
        end
    end

    task automatic bus_wr(input logic [31:0] off, input logic [31:0] d);
        @(negedge clk);
        addr = BASE + off; wdat = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] off, output logic [31:0] d);
        @(negedge clk);
        addr = BASE + off; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic rd_res();
        logic [31:0] d, e;
        bus_rd(OFF_R, d);
        e = (rq.size() != 0) ? rq.pop_front() : 32'h0;
        chk("r_data", d, e);
    endtask

    task automatic rd_stat(input string tag, input logic [31:0] e);
        logic [31:0] d;
        bus_rd(OFF_CTRL, d);
        chk(tag, d, e);
    endtask

    task automatic pulse_done(input logic [31:0] r);
        @(negedge clk);
        mdone = 1'b1; mresult = r;
        @(negedge clk);
        mdone = 1'b0; mresult = '0;
    endtask

    // One compute: start, check a single start pulse, optionally peek BUSY,
    // return the result after dly cycles, then wait (bounded) for idle.
    task automatic compute(input logic [31:0] r, input int dly, input bit lands, input bit peek);
        int starts = 0;
        logic [31:0] d;
        bus_wr(OFF_CTRL, 32'h1);
        repeat (3) begin
            starts += int'(mstart);
            @(negedge clk);
        end
        chk("start_pulses", 32'(starts), 32'd1);
        if (peek) begin
            bus_rd(OFF_CTRL, d);
            chk("busy_bit", 32'(d[ST_BUSY]), 32'd1);
        end
        repeat (dly) @(negedge clk);
        pulse_done(r);
        if (lands) rq.push_back(r);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("idle_after_capture", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int cyc;

        repeat (3) @(negedge clk);
        chk("rst_outs", {rdata[7:0], 7'd0, mwe, mwdata[7:0], 3'd0, mstart, mode, 3'd0, busy},
            32'h0);
        chk("rst_act_vref", act | vref, 32'h0);
        rst_n = 1'b1;

        // Done outside WAIT is ignored; unmapped read returns 0
        pulse_done(32'hBAD0_BAD0);
        rd_stat("stat_after_idle_done", 32'h0);
        bus_rd(32'h800, d);
        chk("unmapped_rd", d, 32'h0);

        // 17 weight writes: rows 0..15 then wrap to 0
        for (int i = 0; i < 17; i++) begin
            wq.push_back({4'(i % 16), 32'h100 + 32'(i)});
            bus_wr(OFF_W_WEIGHT, 32'h100 + 32'(i));
        end
        @(negedge clk);

        // Key-gated VREF/MODE; activation
        bus_wr(OFF_W_VREF, 32'h55);
        chk("vref_locked", vref, 32'h0);
        bus_wr(OFF_W_KEY, 32'hC0DE);
        bus_wr(OFF_W_VREF, 32'h55);
        chk("vref_unlocked", vref, 32'h55);
        bus_wr(OFF_W_MODE, 32'hA);
        chk("mode", 32'(mode), 32'hA);
        bus_wr(OFF_W_ACTIVATION, 32'h1234_5678);
        chk("act", act, 32'h1234_5678);

        // Normal compute
        compute(32'hDEAD_BEEF, 10, 1'b1, 1'b1);
        rd_stat("stat_done", 32'h0000_0102);
        rd_res();
        rd_stat("stat_drained", 32'h0);

        // Timeout: ARM + TIMEOUT WAIT cycles
        bus_wr(OFF_CTRL, 32'h1);
        cyc = 0;
        while (busy && cyc < 1200) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_latency", 32'(cyc), 32'd1025);
        rd_stat("stat_to", 32'h8);
        bus_wr(OFF_CTRL, 32'h2);
        rd_stat("stat_to_clr", 32'h0);

        // Overflow: five results into a four-deep FIFO
        for (int i = 1; i <= 5; i++) compute(32'(i), 2, i <= 4, 1'b0);
        rd_stat("stat_ovf", 32'h0000_0412);
        repeat (5) rd_res();
        rd_stat("stat_after_drain", 32'h10);
        bus_wr(OFF_CTRL, 32'h2);

        // Busy weight write sets ERR, then reset mid-WAIT
        compute(32'h77, 2, 1'b1, 1'b0);
        bus_wr(OFF_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        bus_wr(OFF_W_WEIGHT, 32'hFFFF);
        rd_stat("stat_err", 32'h0000_0107);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_start", {30'd0, busy, mstart}, 32'h0);
        chk("rst_vref_act", vref | act, 32'h0);
        chk("rst_mode_we", {27'd0, mode, mwe}, 32'h0);
        rq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rd_stat("stat_after_rst", 32'h0);
        rd_res();

        chk("we_all_seen", 32'(wq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pim_ctrl.md
Name: pim_ctrl

Overview:
- Memory-mapped PIM macro controller; sits directly downstream of the core's PIM slave port (registered addr/wr_data plus strobes) and drives the analog PIM macro.
- Accepts weight, activation, key, vref and mode writes from the core/DMA and sequences one compute operation per start command.
- Captures macro results into a small FIFO that software or DMA drains by reading the result register.

Parameters:
- XLEN, 32, bus data/address width
- BASE, 32'h4000_0000, base address; register offsets below are relative to it
- ROWS, 16, weight rows in macro (power of 2); row pointer width RAW = $clog2(ROWS)
- RES_DEPTH, 4, result FIFO depth (power of 2)
- TIMEOUT, 1024, max cycles to wait for macro done
- UNLOCK_KEY, 32'h0000_C0DE, key value enabling VREF/MODE writes

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_pim_addr  in  XLEN  byte address from bus
- i_pim_wr_data  in  XLEN  write data
- i_pim_write  in  1  write strobe, one cycle per access
- i_pim_read  in  1  read strobe, one cycle per access
- o_pim_rd_data  out  XLEN  read data, valid the cycle after i_pim_read
- o_macro_we  out  1  weight row write pulse
- o_macro_row  out  RAW  weight row index
- o_macro_wdata  out  XLEN  weight row data
- o_macro_act  out  XLEN  activation vector (held)
- o_macro_vref  out  XLEN  reference voltage code (held)
- o_macro_mode  out  4  operating mode (held)
- o_macro_start  out  1  compute start pulse
- i_macro_done  in  1  compute complete, one-cycle pulse
- i_macro_result  in  XLEN  result, valid with i_macro_done
- o_busy  out  1  compute in progress

Behaviour:
- Register offsets: CTRL 0x010, R 0x020, W_WEIGHT 0x040, W_ACTIVATION 0x080, W_KEY 0x100, W_VREF 0x200, W_MODE 0x400. Accesses to unmapped offsets: writes ignored, reads return 0.
- Reset: all outputs 0, row pointer 0, FIFO empty, status flags cleared, key 0, state IDLE.
- W_WEIGHT write in cycle N: o_macro_we=1 with o_macro_row=wptr and o_macro_wdata=data in cycle N+1. wptr then increments, wrapping ROWS-1 to 0.
- W_WEIGHT write while busy: dropped, wptr unchanged, sticky ERR set.
- W_ACTIVATION write updates o_macro_act at N+1. While busy it is dropped and ERR is set.
- W_KEY stores the written word. W_VREF/W_MODE update only if key==UNLOCK_KEY; otherwise ignored. The key is not auto-cleared.
- CTRL write:
  - bit0=1 starts a compute if IDLE; ignored if busy.
  - bit1=1 clears the ERR/TO/OVF sticky flags.
  - bit2=1 resets wptr to 0.
- CTRL read returns {fifo_count[7:0] at [15:8], OVF[4], TO[3], ERR[2], DONE[1], BUSY[0]}. DONE is sticky and clears on a CTRL read.
- FSM:
  - IDLE: on start, go to ARM.
  - ARM: o_macro_start=1 for exactly one cycle; clear timeout counter; go to WAIT.
  - WAIT: count cycles. On i_macro_done go to CAPTURE. If the counter reaches TIMEOUT-1 without done, set TO and go to IDLE with no push and DONE not set.
  - CAPTURE: push the result latched on done; set DONE; go to IDLE.
- o_busy=1 in ARM/WAIT/CAPTURE.
- i_macro_done outside WAIT is ignored.
- R read: returns the FIFO head at N+1 and pops it. If the FIFO is empty, returns 0 with no pop and no error.
- Push while full: if a pop occurs the same cycle, both happen and count is unchanged. Otherwise the result is dropped and OVF is set.
- Simultaneous i_pim_write and i_pim_read: both processed independently.
- Reset mid-compute: immediate return to IDLE, o_macro_start deasserted, FIFO cleared.

Decomposition:
- pim_pkg holds:
  - register offset localparams and the CTRL bit-position constants
  - state enum typedef (IDLE, ARM, WAIT, CAPTURE)
  - UNLOCK_KEY default
- Sub-module pim_res_fifo: synchronous FIFO, parameters DEPTH/WIDTH; push, pop, full, empty, count; head readable combinationally. Behaviour on simultaneous push/pop when full is as above.

Test Plan:
- 17 W_WEIGHT writes 0x100..0x110 -> o_macro_we pulses with rows 0..15 then 0. Row 0 last carries 0x110.
- W_VREF 0x55 with key 0 -> o_macro_vref stays 0. Then W_KEY 0xC0DE and W_VREF 0x55 -> o_macro_vref=0x55 next cycle.
- CTRL write 0x1, macro returns done with 0xDEAD_BEEF after 10 cycles -> one-cycle o_macro_start. CTRL read shows BUSY until capture, then DONE=1, count=1. R read returns 0xDEAD_BEEF, then count=0.
- Start with no i_macro_done -> after 1024 cycles TO=1, BUSY=0, FIFO count 0. CTRL write 0x2 clears TO.
- Five computes with no R reads -> count=4, OVF=1, the fifth result lost. Four R reads return results 1..4 in order; a fifth R read returns 0.
- W_WEIGHT during WAIT plus i_rst_n asserted mid-WAIT -> ERR set before reset. After reset all outputs 0, state IDLE.
